data_mem_dma: RTL and testbench

Initiator-side engine for the 16-bit x 1024-word DataMemory. On a start pulse it drives the memory's address/writeData/memRead/memWrite pins to either block-copy words from a source region to a destination region, or fill a region with a constant. It sits beside the datapath and owns the memory bus only while busy; a top-level mux gives the processor the bus otherwise.

---
 rtl/data_mem_dma.sv | 96 +++++++++
 tb/tb_data_mem_dma.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_dma.sv
// data_mem_dma: block-copy / constant-fill initiator for the 16-bit x 1024-word DataMemory
// Ports: clk, rstN (async active-low); start/mode/srcAddr/dstAddr/len/fillValue request a job;
// address/writeData/memRead/memWrite drive the memory from flops; readData is memory read data;
// busy covers READ/WRITE/DONE, done pulses one cycle, count holds words completed.
module data_mem_dma #(
  parameter int WORD = 16,
  parameter int ADDRESSL = 10
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDRESSL-1:0] srcAddr,
  input  logic [ADDRESSL-1:0] dstAddr,
  input  logic [ADDRESSL:0]   len,
  input  logic [WORD-1:0]     fillValue,
  output logic [ADDRESSL-1:0] address,
  output logic [WORD-1:0]     writeData,
  output logic                memRead,
  output logic                memWrite,
  input  logic [WORD-1:0]     readData,
  output logic                busy,
  output logic                done,
  output logic [ADDRESSL:0]   count
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state;
  logic [ADDRESSL-1:0] src, dst;
  logic [ADDRESSL:0] len_q, nxt;
  logic mode_q;
  assign nxt = count + (ADDRESSL+1)'(1);
  // In fill mode writeData is loaded once with fillValue and simply held, so no separate fill register
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      state <= IDLE;
      address <= '0;
      writeData <= '0;
      memRead <= 1'b0;
      memWrite <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      count <= '0;
      src <= '0;
      dst <= '0;
      len_q <= '0;
      mode_q <= 1'b0;
    end else
      case (state)
        IDLE: begin
          memRead <= 1'b0;
          memWrite <= 1'b0;
          busy <= start;
          done <= start && len == '0;
          if (start) begin
            count <= '0;
            if (len == '0) state <= DONE;
            else begin
              src <= srcAddr;
              dst <= dstAddr;
              len_q <= len;
              mode_q <= mode;
              state <= mode ? WRITE : READ;
              memRead <= !mode;
              memWrite <= mode;
              address <= mode ? dstAddr : srcAddr;
              if (mode) writeData <= fillValue;
            end
          end
        end
        READ: begin
          state <= WRITE;
          memRead <= 1'b0;
          memWrite <= 1'b1;
          address <= dst + count[ADDRESSL-1:0];
          writeData <= readData;
        end
        WRITE: begin
          count <= nxt;
          if (nxt == len_q) begin
            state <= DONE;
            memWrite <= 1'b0;
            done <= 1'b1;
          end else if (!mode_q) begin
            state <= READ;
            memWrite <= 1'b0;
            memRead <= 1'b1;
            address <= src + nxt[ADDRESSL-1:0];
          end else address <= dst + nxt[ADDRESSL-1:0];
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_data_mem_dma.sv
// tb_data_mem_dma: randomized self-checking bench with a memory model and array-level reference
module tb_data_mem_dma;
  logic clk = 1'b0, rstN = 1'b1, start = 1'b0, mode = 1'b0;
  logic [9:0] srcAddr = '0, dstAddr = '0;
  logic [10:0] len = '0;
  logic [15:0] fillValue = '0;
  logic [9:0] address;
  logic [15:0] writeData, readData;
  logic memRead, memWrite, busy, done;
  logic [10:0] count;
  logic [15:0] mem [1024];
  logic [15:0] ref_mem [1024];
  logic poke = 1'b0;
  logic [9:0] paddr = '0;
  logic [15:0] pdata = '0;
  int checks = 0, fails = 0, both = 0, nw = 0, nr = 0, cyc = 0, t0 = 0;
  always #5 clk = ~clk;
  data_mem_dma dut (
    .clk(clk), .rstN(rstN), .start(start), .mode(mode), .srcAddr(srcAddr), .dstAddr(dstAddr),
    .len(len), .fillValue(fillValue), .address(address), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .readData(readData), .busy(busy), .done(done),
    .count(count)
  );
  assign readData = mem[address];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (memWrite) begin
      mem[address] <= writeData;
      nw <= nw + 1;
    end else if (poke) mem[paddr] <= pdata;
    if (memRead) nr <= nr + 1;
  end
  always @(negedge clk) if (memRead && memWrite) both <= both + 1;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic poke_word(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    poke = 1'b1;
    paddr = a;
    pdata = d;
    @(posedge clk);
    #1 poke = 1'b0;
    ref_mem[a] = d;
  endtask
  task automatic mem_check(input string tag);
    int bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
  endtask
  // Reference: ascending word-by-word transfer over a circular 1024-word array
  task automatic model(input logic m, input logic [9:0] s, input logic [9:0] d, input int l, input logic [15:0] f);
    logic [9:0] a, b;
    for (int i = 0; i < l; i++) begin
      a = d + i[9:0];
      b = s + i[9:0];
      ref_mem[a] = m ? f : ref_mem[b];
    end
  endtask
  task automatic launch(input logic m, input logic [9:0] s, input logic [9:0] d, input logic [10:0] l, input logic [15:0] f);
    @(negedge clk);
    mode = m;
    srcAddr = s;
    dstAddr = d;
    len = l;
    fillValue = f;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
  endtask
  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 2200) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic finish_job(input string tag, input logic m, input int l, input int nw0, input int nr0);
    wait_done();
    check({tag, " done"}, done, 1);
    check({tag, " latency"}, cyc - t0, l == 0 ? 0 : (m ? l : 2 * l));
    check({tag, " busy@done"}, busy, 1);
    check({tag, " count"}, count, l);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
    check({tag, " busy_idle"}, busy, 0);
    check({tag, " writes"}, nw - nw0, l);
    check({tag, " reads"}, nr - nr0, m ? 0 : l);
    check({tag, " both_strobes"}, both, 0);
    mem_check({tag, " mem"});
  endtask
  task automatic run(input string tag, input logic m, input logic [9:0] s, input logic [9:0] d, input logic [10:0] l, input logic [15:0] f);
    int nw0 = nw, nr0 = nr;
    launch(m, s, d, l, f);
    model(m, s, d, int'(l), f);
    finish_job(tag, m, int'(l), nw0, nr0);
  endtask
  initial begin
    int nw0, nr0, n;
    #2 rstN = 1'b0;
    for (int i = 0; i < 1024; i++) poke_word(i[9:0], 16'($urandom));
    check("rst address", address, 0);
    check("rst strobes", {memRead, memWrite, busy, done}, 0);
    check("rst count", count, 0);
    @(negedge clk) rstN = 1'b1;
    for (int i = 0; i < 4; i++) poke_word(10'(10 + i), 16'(i + 1));
    run("copy_basic", 1'b0, 10'd10, 10'd100, 11'd4, 16'h0);
    check("copy_basic word103", mem[103], 16'd4);
    run("fill_wrap", 1'b1, 10'd0, 10'd1022, 11'd4, 16'hA5A5);
    check("fill_wrap word0", mem[0], 16'hA5A5);
    run("zero_len", 1'b0, 10'd5, 10'd6, 11'd0, 16'h0);
    poke_word(10'd0, 16'd7);
    run("overlap", 1'b0, 10'd0, 10'd1, 11'd3, 16'h0);
    check("overlap word3", mem[3], 16'd7);
    // start while busy: a second request with different parameters must be dropped
    nw0 = nw;
    nr0 = nr;
    launch(1'b0, 10'd400, 10'd500, 11'd6, 16'h0);
    model(1'b0, 10'd400, 10'd500, 6, 16'h0);
    repeat (3) @(negedge clk);
    mode = 1'b1;
    dstAddr = 10'd600;
    len = 11'd2;
    fillValue = 16'h1234;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    finish_job("busy_ignore", 1'b0, 6, nw0, nr0);
    // start during the DONE cycle is dropped
    nw0 = nw;
    launch(1'b1, 10'd0, 10'd700, 11'd3, 16'hBEEF);
    model(1'b1, 10'd0, 10'd700, 3, 16'hBEEF);
    wait_done();
    check("done_start done", done, 1);
    dstAddr = 10'd800;
    len = 11'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("done_start ignored busy", busy, 0);
    check("done_start ignored writes", nw - nw0, 3);
    mem_check("done_start mem");
    run("after_done", 1'b1, 10'd0, 10'd900, 11'd2, 16'h5A5A);
    // asynchronous reset in the middle of a copy
    nw0 = nw;
    nr0 = nr;
    launch(1'b0, 10'd200, 10'd300, 11'd8, 16'h0);
    n = 0;
    @(negedge clk);
    while (!(memWrite && count == 11'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid in_write", memWrite, 1);
    rstN = 1'b0;
    #1;
    check("rst_mid strobes", {memRead, memWrite, busy, done}, 0);
    check("rst_mid address", address, 0);
    check("rst_mid wdata", writeData, 0);
    check("rst_mid count", count, 0);
    model(1'b0, 10'd200, 10'd300, 3, 16'h0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid writes", nw - nw0, 3);
    check("rst_mid reads", nr - nr0, 4);
    check("rst_mid idle", busy, 0);
    mem_check("rst_mid mem");
    run("fill_full", 1'b1, 10'd0, 10'd17, 11'd1024, 16'hC3C3);
    for (int i = 0; i < 1024; i++) poke_word(i[9:0], 16'($urandom));
    run("copy_full", 1'b0, 10'd600, 10'd3, 11'd1024, 16'h0);
    for (int j = 0; j < 25; j++)
      run("rand", 1'($urandom), 10'($urandom), 10'($urandom), 11'($urandom_range(0, 40)), 16'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
